// File: rtl/pipeline_stage_reg.sv
// Inter-stage pipeline register with a registered-ready 2-entry skid buffer,
// flush-to-NOP, a free-running sideband and a saturating bubble counter.
module pipeline_stage_reg #(
   parameter int                 DATA_W    = 96,
   parameter logic [DATA_W-1:0]  NOP_VALUE = '0,
   parameter int                 SIDE_W    = 1,
   parameter logic [SIDE_W-1:0]  SIDE_RST  = SIDE_W'(1),
   parameter int                 CNT_W     = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   input  logic              flush,
   input  logic [SIDE_W-1:0] side_in,
   output logic [SIDE_W-1:0] side_out,
   output logic [CNT_W-1:0]  bubble_cnt,
   input  logic              bubble_clr
);

   typedef enum logic [1:0] {EMPTY, MAIN, SKID} state_t;

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   main_q, main_d;
   logic [DATA_W-1:0]   skid_q, skid_d;
   logic                in_ready_q, in_ready_d;
   logic                out_valid_q, out_valid_d;
   logic [SIDE_W-1:0]   side_q, side_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;

   // main always holds NOP_VALUE when empty, so out_data needs no output mux
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      side_d  = side_in;
      cnt_d   = cnt_q;

      if (flush) begin
         state_d = EMPTY;
         main_d  = NOP_VALUE;
         skid_d  = NOP_VALUE;
      end else begin
         case (state_q)
            EMPTY: begin
               if (in_valid) begin
                  main_d  = in_data;
                  state_d = MAIN;
               end
            end
            MAIN: begin
               if (out_ready) begin
                  if (in_valid) begin
                     main_d = in_data;
                  end else begin
                     main_d  = NOP_VALUE;
                     state_d = EMPTY;
                  end
               end else if (in_valid) begin
                  skid_d  = in_data;
                  state_d = SKID;
               end
            end
            SKID: begin
               if (out_ready) begin
                  main_d  = skid_q;
                  skid_d  = NOP_VALUE;
                  state_d = MAIN;
               end
            end
            default: begin
               state_d = EMPTY;
               main_d  = NOP_VALUE;
               skid_d  = NOP_VALUE;
            end
         endcase
      end

      out_valid_d = (state_d != EMPTY);
      in_ready_d  = (state_d != SKID);

      // Clear wins over a same-cycle increment; the count sticks at all-ones
      if (bubble_clr) begin
         cnt_d = '0;
      end else if (!out_valid_q && out_ready && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= EMPTY;
         main_q      <= NOP_VALUE;
         skid_q      <= NOP_VALUE;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         side_q      <= SIDE_RST;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         main_q      <= main_d;
         skid_q      <= skid_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         side_q      <= side_d;
         cnt_q       <= cnt_d;
      end
   end

   assign in_ready   = in_ready_q;
   assign out_valid  = out_valid_q;
   assign out_data   = main_q;
   assign side_out   = side_q;
   assign bubble_cnt = cnt_q;

endmodule

// File: doc/pipeline_stage_reg.md
Name: pipeline_stage_reg

Overview:
- Parametrised inter-stage pipeline register with a valid/ready handshake on both sides and a 2-entry skid buffer, so `in_ready` is a registered signal and is not combinationally dependent on `out_ready`.
- Sits between decode and execute, and between execute and memory, in the CPU32 pipeline.
- Generalises the stage register: configurable payload width, configurable NOP encoding, flush-to-NOP, pass-through sideband and a saturating bubble counter.

Parameters:
- DATA_W, 96: payload width in bits (the packed execute/memory/register-op control bundle).
- NOP_VALUE, 0: value driven on `out_data` whenever the stage holds no valid beat (clean NOP).
- SIDE_W, 1: width of the always-passing sideband (e.g. pcincr).
- SIDE_RST, 1: reset value of `side_out`.
- CNT_W, 16: width of the bubble counter.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  upstream beat present.
- in_ready  out  1  stage can accept a beat; registered.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  `out_data` holds a valid beat.
- out_ready  in  1  downstream accepts the beat this cycle.
- out_data  out  DATA_W  head payload; equals NOP_VALUE when `out_valid`=0.
- flush  in  1  discard all held beats and the beat presented this cycle.
- side_in  in  SIDE_W  sideband input.
- side_out  out  SIDE_W  sideband, registered every cycle.
- bubble_cnt  out  CNT_W  saturating count of starved cycles.
- bubble_clr  in  1  synchronous clear of `bubble_cnt`.

Behaviour:
- Reset (`rst`=1 at the clk edge) sets:
  - state EMPTY, `out_valid`=0, `out_data`=NOP_VALUE, skid register=NOP_VALUE;
  - `in_ready`=1, `side_out`=SIDE_RST, `bubble_cnt`=0.
  - Reset overrides every other input, including mid-transfer. Any held beats are lost.
- Handshake:
  - An upstream transfer occurs when `in_valid` & `in_ready` at a clk edge.
  - A downstream transfer occurs when `out_valid` & `out_ready` at a clk edge.
  - Latency is 1 cycle: data accepted at edge N is visible on `out_data` after edge N when the stage was EMPTY, or when it was in MAIN with `out_ready`=1.
- State machine, evaluated only when `rst`=0 and `flush`=0:
  - EMPTY (`out_valid`=0, `in_ready`=1):
    - `in_valid`=1: main <= `in_data`, go to MAIN.
    - Otherwise: stay in EMPTY.
  - MAIN (`out_valid`=1, `in_ready`=1):
    - `out_ready`=1 & `in_valid`=1: main <= `in_data`, stay in MAIN.
    - `out_ready`=1 & `in_valid`=0: main <= NOP_VALUE, go to EMPTY.
    - `out_ready`=0 & `in_valid`=1: skid <= `in_data`, go to SKID, `in_ready` <= 0.
    - `out_ready`=0 & `in_valid`=0: hold.
  - SKID (`out_valid`=1, `in_ready`=0):
    - `out_ready`=1: main <= skid, skid <= NOP_VALUE, go to MAIN, `in_ready` <= 1.
    - Otherwise: hold.
    - `in_valid` is ignored in SKID.
- Ordering: beats leave in strict arrival order. No beat is duplicated or dropped except by flush or reset.
- Flush (`rst`=0, `flush`=1):
  - Next state EMPTY; main and skid <= NOP_VALUE; `out_valid` <= 0; `in_ready` <= 1.
  - A beat presented in the flush cycle is discarded, even though `in_ready` may be 1.
  - A downstream handshake in the flush cycle still counts as completed.
  - Flush is legal in every state.
- Sideband: `side_out` <= `side_in` every non-reset cycle, regardless of flush, stall or state.
- Bubble counter:
  - Increments when `out_valid`=0 & `out_ready`=1 at a clk edge.
  - Saturates at 2^CNT_W-1; no wrap.
  - `bubble_clr` clears it to 0 and has priority over the increment.
  - Flush does not affect it.
- All outputs come directly from registers. There are no combinational paths from inputs to outputs.

Test Plan:
- Reset with DATA_W=96, NOP_VALUE=0: assert `rst` 2 cycles with `in_valid`=1 -> `out_valid`=0, `out_data`=0, `in_ready`=1, `side_out`=1, `bubble_cnt`=0; no beat captured.
- Streaming: `out_ready`=1, push beats 0x11, 0x22, 0x33 on consecutive cycles -> each appears on `out_data` one cycle later, `out_valid`=1 for 3 consecutive cycles, `in_ready` stays 1.
- Back-pressure: `out_ready`=0 while pushing 0xA1, 0xA2 -> state SKID, `in_ready`=0, `out_data`=0xA1. `in_valid` with 0xA3 is ignored. Release `out_ready` -> outputs 0xA1 then 0xA2, then `in_ready`=1.
- Flush in SKID holding 0xB1, 0xB2 with 0xB3 presented: `flush`=1 for 1 cycle -> `out_valid`=0, `out_data`=NOP_VALUE, `in_ready`=1; 0xB1, 0xB2 and 0xB3 are never output.
- Bubble counter, CNT_W=2: `out_valid`=0, `out_ready`=1 for 5 cycles -> `bubble_cnt` reads 1, 2, 3, 3, 3. `bubble_clr`=1 with an increment condition present in the same cycle -> reads 0.
- Sideband: toggle `side_in` each cycle during SKID and during flush -> `side_out` follows with exactly 1-cycle delay throughout.
